// File: rtl/ha_array_pkg.sv
// ha_array_pkg: shared constants, FSM state enum and row-pair type
// for the ha_array partial-product accumulator.
package ha_array_pkg;

  localparam int ROWS      = 4;
  localparam int ROW_SHIFT = 2;
  localparam int T_W       = 9;
  localparam int B_W       = 7;
  localparam int B_OFS     = 2;
  localparam int P_W       = 16;

  // two guard bits catch the wrap past 2^P_W
  localparam int ACC_W = P_W + 2;
  localparam int CNT_W = $clog2(ROWS);
  localparam int SH_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_e;

  typedef struct packed {
    logic [B_W-1:0] b;
    logic [T_W-1:0] t;
  } row_pair_t;

endpackage

// File: rtl/ha_row_weight.sv
// ha_row_weight: combinational weight of one row pair.
// Ports: row_i (b,t pair), idx_i (row index), contrib_o (ACC_W-bit value).
module ha_row_weight
  import ha_array_pkg::*;
(
  input  row_pair_t        row_i,
  input  logic [CNT_W-1:0] idx_i,
  output logic [ACC_W-1:0] contrib_o
);

  logic [SH_W-1:0]  sh_t;
  logic [SH_W-1:0]  sh_b;
  logic [ACC_W-1:0] t_ext;
  logic [ACC_W-1:0] b_ext;

  always_comb begin
    sh_t  = SH_W'(ROW_SHIFT) * SH_W'(idx_i);
    sh_b  = sh_t + SH_W'(B_OFS);
    t_ext = ACC_W'(row_i.t);
    b_ext = ACC_W'(row_i.b);
    contrib_o = (t_ext << sh_t) + (b_ext << sh_b);
  end

endmodule

// File: rtl/ha_array_accumulator.sv
// ha_array_accumulator: captures four (b,t) rows, sums one row per cycle,
// returns product/overflow. Ports: clk, rst, in_valid/in_ready, row inputs,
// out_valid/out_ready, product, overflow.
module ha_array_accumulator
  import ha_array_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [T_W-1:0] ha_array_0_t,
  input  logic [B_W-1:0] ha_array_0_b,
  input  logic [T_W-1:0] ha_array_1_t,
  input  logic [B_W-1:0] ha_array_1_b,
  input  logic [T_W-1:0] ha_array_2_t,
  input  logic [B_W-1:0] ha_array_2_b,
  input  logic [T_W-1:0] ha_array_3_t,
  input  logic [B_W-1:0] ha_array_3_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] product,
  output logic           overflow
);

  state_e                 state_q, state_d;
  row_pair_t [ROWS-1:0]   rows_q, rows_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [P_W-1:0]         product_q, product_d;
  logic                   overflow_q, overflow_d;

  row_pair_t              cur_row;
  logic [ACC_W-1:0]       contrib;

  assign cur_row = rows_q[cnt_q];

  ha_row_weight u_weight (
    .row_i     (cur_row),
    .idx_i     (cnt_q),
    .contrib_o (contrib)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rows_d[0].t = ha_array_0_t;
          rows_d[0].b = ha_array_0_b;
          rows_d[1].t = ha_array_1_t;
          rows_d[1].b = ha_array_1_b;
          rows_d[2].t = ha_array_2_t;
          rows_d[2].b = ha_array_2_b;
          rows_d[3].t = ha_array_3_t;
          rows_d[3].b = ha_array_3_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + contrib;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ROWS - 1)) begin
          // result registers load once, then hold until the next set
          product_d  = acc_d[P_W-1:0];
          overflow_d = |acc_d[ACC_W-1:P_W];
          state_d    = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign product  = product_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// tb_ha_array_accumulator: directed-vector bench for ha_array_accumulator
// and ha_row_weight with hand-computed expected values.
module tb_ha_array_accumulator;
  import ha_array_pkg::*;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0][8:0]  tv;
  logic [3:0][6:0]  bv;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      product;
  logic             overflow;

  row_pair_t        w_row;
  logic [CNT_W-1:0] w_idx;
  logic [ACC_W-1:0] w_contrib;

  int n_chk;
  int n_fail;

  ha_array_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_t (tv[0]),
    .ha_array_0_b (bv[0]),
    .ha_array_1_t (tv[1]),
    .ha_array_1_b (bv[1]),
    .ha_array_2_t (tv[2]),
    .ha_array_2_b (bv[2]),
    .ha_array_3_t (tv[3]),
    .ha_array_3_b (bv[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .overflow     (overflow)
  );

  ha_row_weight u_ref_w (
    .row_i     (w_row),
    .idx_i     (w_idx),
    .contrib_o (w_contrib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [3:0][8:0] t,
                        input logic [3:0][6:0] b);
    tv = t;
    bv = b;
    in_valid = 1'b1;
    check("in_ready_at_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // scramble inputs: only registered copies may be used
    tv = '1;
    bv = '1;
  endtask

  task automatic collect(input string tag,
                         input logic [15:0] ep,
                         input logic eo,
                         input int stall);
    int cyc;
    logic [15:0] held;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd4);
    check({tag, "_product"}, 32'(product), 32'(ep));
    check({tag, "_overflow"}, 32'(overflow), 32'(eo));
    held = product;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_stall_prod"}, 32'(product), 32'(held));
      check({tag, "_stall_ovf"}, 32'(overflow), 32'(eo));
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_inrdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_inrdy"}, 32'(in_ready), 32'd1);
    check({tag, "_prod_kept"}, 32'(product), 32'(ep));
    tv = '0;
    bv = '0;
  endtask

  initial begin
    int seen;
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tv        = '0;
    bv        = '0;
    w_row     = '0;
    w_idx     = '0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // idle with in_valid low captures nothing
    repeat (3) @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // row weight unit: 511*64 + 127*256 = 65216
    w_row.t = 9'h1FF;
    w_row.b = 7'h7F;
    w_idx   = 2'd3;
    #1;
    check("w_row3_ones", 32'(w_contrib), 32'd65216);
    w_row.t = 9'h001;
    w_row.b = 7'h00;
    w_idx   = 2'd1;
    #1;
    check("w_row1_t1", 32'(w_contrib), 32'd4);
    w_row.t = 9'h000;
    w_row.b = 7'h01;
    w_idx   = 2'd0;
    #1;
    check("w_row0_b1", 32'(w_contrib), 32'd4);

    accept('0, '0);
    collect("zero", 16'h0000, 1'b0, 0);

    accept({9'h0, 9'h0, 9'h0, 9'h001}, '0);
    collect("t0_lsb", 16'h0001, 1'b0, 0);

    accept({9'h100, 9'h0, 9'h0, 9'h0}, {7'h40, 7'h0, 7'h0, 7'h0});
    collect("row3_msb", 16'h8000, 1'b0, 0);

    // 680 + 340 = 1020
    accept({9'h0, 9'h0, 9'h0AA, 9'h0}, {7'h0, 7'h0, 7'h0, 7'h55});
    collect("mixed", 16'h03FC, 1'b0, 0);

    // 1019 * 85 = 86615 -> wraps to 0x5257
    accept({4{9'h1FF}}, {4{7'h7F}});
    collect("all_ones", 16'h5257, 1'b1, 10);

    // second set after the long stall: 127 << 6 = 0x1FC0
    accept('0, {7'h0, 7'h7F, 7'h0, 7'h0});
    collect("after_stall", 16'h1FC0, 1'b0, 0);

    // abort mid-accumulation
    accept({4{9'h1FF}}, {4{7'h7F}});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_pulse", 32'(seen), 32'd0);

    accept({9'h0, 9'h0, 9'h0, 9'h001}, '0);
    collect("post_abort", 16'h0001, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
